// File: rtl/bs_pkg.sv
// Shared definitions for the bus-system generator (round-robin variant).
// Holds the FSM state type, packet field offsets, the default broadcast
// target value and the destination-mask builder used in DECODE.
package bs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_DECODE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PUSH   = 3'd4
  } state_t;

  // Largest supported driver count; masks are built at this width and
  // truncated by the user.
  localparam int MAX_DRVRS = 16;

  // Field MSBs expressed as distance below the packet width:
  // the field MSB sits at bit index PCKG_SZ - <X>_MSB.
  localparam int TGT_MSB = 1;
  localparam int SRC_MSB = 9;
  localparam int ID_MSB  = 17;

  localparam logic [7:0] BROADCAST_DFLT = 8'hFF;

  // Destination mask for a packet from driver 'grant' addressed to 'target'.
  // Broadcast hits every driver except the source; a target below drvrs is
  // one-hot (self-addressing allowed); anything else yields an empty mask.
  function automatic logic [MAX_DRVRS-1:0] build_dest_mask(
    input logic [7:0] target,
    input logic [3:0] grant,
    input int         drvrs,
    input logic [7:0] bcast
  );
    logic [MAX_DRVRS-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DRVRS; i++) begin
      if (i < drvrs) begin
        if (target == bcast) begin
          mask[i] = (i != int'(grant));
        end else begin
          mask[i] = (int'(target) == i);
        end
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Ports:
//   req  in  DRVRS  request vector
//   ptr  in  GW     index of the highest-priority requester
//   gnt  out DRVRS  one-hot grant (all zero when no request)
//   idx  out GW     index of the granted requester
// The priority pointer register lives in the parent.
module rr_arbiter #(
  parameter int DRVRS = 4,
  parameter int GW    = 2
) (
  input  logic [DRVRS-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [DRVRS-1:0] gnt,
  output logic [GW-1:0]    idx
);

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < DRVRS; k++) begin
      j = int'(ptr) + k;
      if (j >= DRVRS) begin
        j = j - DRVRS;
      end else begin
        j = j;
      end
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = GW'(j);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/bs_gnrtr_rr.sv
// Bus-system generator with round-robin arbitration.
// Pops one packet at a time from DRVRS first-word-fall-through driver FIFOs,
// decodes its target byte and pushes it to one destination or, for
// broadcast, to every driver except the source. Unknown targets are dropped
// and counted. All outputs come straight from registers.
// Ports:
//   clk      in  1              rising-edge clock
//   reset    in  1              asynchronous active-low reset
//   pndng    in  DRVRS          driver FIFO i has a packet at its head
//   D_pop    in  DRVRS*PCKG_SZ  head packets, lane i at [i*PCKG_SZ +: PCKG_SZ]
//   full     in  DRVRS          destination FIFO i cannot accept a push
//   pop      out DRVRS          one-cycle pop strobe
//   push     out DRVRS          one-cycle push strobe
//   D_push   out DRVRS*PCKG_SZ  pushed packet, replicated on every lane
//   drop_cnt out CNT_W          saturating count of dropped packets
//   busy     out 1              FSM is outside IDLE
module bs_gnrtr_rr
  import bs_pkg::*;
#(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 128,
  parameter logic [7:0] BROADCAST = BROADCAST_DFLT,
  parameter int         CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       busy
);

  localparam int GW = $clog2(DRVRS);

  state_t               state_r, state_nxt_s;
  logic [GW-1:0]        ptr_r, ptr_nxt_s;
  logic [GW-1:0]        grant_r, grant_nxt_s;
  logic [DRVRS-1:0]     gnt_r, gnt_nxt_s;
  logic [PCKG_SZ-1:0]   pkt_r, pkt_nxt_s;
  logic [DRVRS-1:0]     dest_r, dest_nxt_s;
  logic [DRVRS-1:0]     pop_r, pop_nxt_s;
  logic [DRVRS-1:0]     push_r, push_nxt_s;
  logic [PCKG_SZ-1:0]   dpush_r, dpush_nxt_s;
  logic [CNT_W-1:0]     drop_r, drop_nxt_s;
  logic                 busy_r;

  logic [DRVRS-1:0]     arb_gnt_s;
  logic [GW-1:0]        arb_idx_s;
  logic [7:0]           tgt_s;
  logic [DRVRS-1:0]     dest_mask_s;
  logic [GW-1:0]        ptr_adv_s;

  rr_arbiter #(
    .DRVRS (DRVRS),
    .GW    (GW)
  ) u_arb (
    .req (pndng),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  assign tgt_s       = pkt_r[PCKG_SZ-TGT_MSB -: 8];
  assign dest_mask_s = DRVRS'(build_dest_mask(tgt_s, 4'(grant_r), DRVRS, BROADCAST));
  // The just-served driver becomes lowest priority.
  assign ptr_adv_s   = (grant_r == GW'(DRVRS-1)) ? '0 : grant_r + GW'(1);

  // Next-state and next-register values for the whole transfer sequence.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    grant_nxt_s = grant_r;
    gnt_nxt_s   = gnt_r;
    pkt_nxt_s   = pkt_r;
    dest_nxt_s  = dest_r;
    pop_nxt_s   = '0;
    push_nxt_s  = '0;
    dpush_nxt_s = dpush_r;
    drop_nxt_s  = drop_r;
    case (state_r)
      ST_IDLE: begin
        if (|pndng) begin
          grant_nxt_s = arb_idx_s;
          gnt_nxt_s   = arb_gnt_s;
          state_nxt_s = ST_POP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_POP: begin
        // Head word is valid before the pop (fall-through), so capture now.
        pop_nxt_s   = gnt_r;
        pkt_nxt_s   = D_pop[int'(grant_r)*PCKG_SZ +: PCKG_SZ];
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        // An empty mask is exactly the unknown-target case.
        if (|dest_mask_s) begin
          dest_nxt_s  = dest_mask_s;
          state_nxt_s = ST_WAIT;
        end else begin
          dest_nxt_s  = '0;
          ptr_nxt_s   = ptr_adv_s;
          state_nxt_s = ST_IDLE;
          if (drop_r != {CNT_W{1'b1}}) begin
            drop_nxt_s = drop_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            drop_nxt_s = drop_r;
          end
        end
      end
      ST_WAIT: begin
        // All destinations must be free together: no partial broadcast.
        if ((dest_r & full) == '0) begin
          push_nxt_s  = dest_r;
          dpush_nxt_s = pkt_r;
          state_nxt_s = ST_PUSH;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_PUSH: begin
        ptr_nxt_s   = ptr_adv_s;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
      gnt_r   <= '0;
      pkt_r   <= '0;
      dest_r  <= '0;
      pop_r   <= '0;
      push_r  <= '0;
      dpush_r <= '0;
      drop_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      grant_r <= grant_nxt_s;
      gnt_r   <= gnt_nxt_s;
      pkt_r   <= pkt_nxt_s;
      dest_r  <= dest_nxt_s;
      pop_r   <= pop_nxt_s;
      push_r  <= push_nxt_s;
      dpush_r <= dpush_nxt_s;
      drop_r  <= drop_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  assign pop      = pop_r;
  assign push     = push_r;
  assign D_push   = {DRVRS{dpush_r}};
  assign drop_cnt = drop_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_bs_gnrtr_rr.sv
module tb_bs_gnrtr_rr;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   pndng = '0;
  logic [511:0] d_pop = '0;
  logic [3:0]   full = '0;
  logic [3:0]   pop, push;
  logic [511:0] d_push;
  logic [15:0]  drop_cnt;
  logic         busy;

  logic [3:0]   pndng2 = '0;
  logic [511:0] d_pop2 = '0;
  logic [3:0]   full2 = '0;
  logic [3:0]   pop2, push2;
  logic [511:0] d_push2;
  logic [1:0]   drop_cnt2;
  logic         busy2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bs_gnrtr_rr u_dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .full(full),
    .pop(pop), .push(push), .D_push(d_push), .drop_cnt(drop_cnt), .busy(busy)
  );

  bs_gnrtr_rr #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .pndng(pndng2), .D_pop(d_pop2), .full(full2),
    .pop(pop2), .push(push2), .D_push(d_push2), .drop_cnt(drop_cnt2), .busy(busy2)
  );

  typedef struct {
    int          drv;
    logic [7:0]  tgt;
    logic [15:0] id;
    logic [3:0]  fl;
    logic [3:0]  exp_push;
    logic [15:0] exp_drop;
  } vec_t;

  function automatic logic [127:0] mk_pkt(input logic [7:0] t, input logic [7:0] s, input logic [15:0] id);
    return {t, s, id, {6{id}}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-driver transfer; the bench FIFO drops pndng when popped.
  task automatic run_txn(input int drv, input logic [127:0] pkt, input logic [3:0] fl,
                         output logic [3:0] pops, output logic [3:0] pushes,
                         output int pop_at, output int push_at, output int push_cycles,
                         output bit timeout);
    pops = '0; pushes = '0; pop_at = -1; push_at = -1; push_cycles = 0; timeout = 1'b1;
    full = fl;
    d_pop = '0;
    d_pop[drv*128 +: 128] = pkt;
    pndng = 4'(1) << drv;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (pop != 4'b0000) begin pops |= pop; pop_at = c; pndng &= ~pop; end
      if (push != 4'b0000) begin pushes |= push; push_at = c; push_cycles++; end
      if (!busy && c > 1) begin timeout = 1'b0; break; end
    end
    pndng = '0;
    full = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    vec_t vecs[9];
    logic [3:0] pops, pushes;
    int pop_at, push_at, push_cycles;
    bit timeout;
    logic [127:0] pkt;
    logic [3:0] seq[5];
    int n;
    bit stall_ok;
    logic [15:0] exp_sat[4];

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    logic [3:0] pops, pushes;
    int pop_at, push_at, push_cycles;
    bit timeout;
    logic [127:0] pkt;
    logic [3:0] seq[5];
    int n;
    bit stall_ok;
    logic [1:0] exp_sat[4];

    vecs[0] = '{0, 8'd2,   16'd5,  4'b0000, 4'b0100, 16'd0};
    vecs[1] = '{3, 8'd0,   16'd6,  4'b0000, 4'b0001, 16'd0};
    vecs[2] = '{1, 8'hFF,  16'd7,  4'b0000, 4'b1101, 16'd0};
    vecs[3] = '{2, 8'd2,   16'd8,  4'b0000, 4'b0100, 16'd0};
    vecs[4] = '{0, 8'd9,   16'd9,  4'b0000, 4'b0000, 16'd1};
    vecs[5] = '{3, 8'hFF,  16'd10, 4'b0000, 4'b0111, 16'd1};
    vecs[6] = '{2, 8'd4,   16'd11, 4'b0000, 4'b0000, 16'd2};
    vecs[7] = '{0, 8'd3,   16'd12, 4'b0111, 4'b1000, 16'd2};
    vecs[8] = '{1, 8'hFF,  16'd13, 4'b0010, 4'b1101, 16'd2};
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3;

    // Reset state
    #1;
    chk("rst_pop", 512'(pop), 512'd0);
    chk("rst_push", 512'(push), 512'd0);
    chk("rst_dpush", d_push, 512'd0);
    chk("rst_drop", 512'(drop_cnt), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table-driven single transfers
    for (int v = 0; v < 9; v++) begin
      pkt = mk_pkt(vecs[v].tgt, 8'(vecs[v].drv), vecs[v].id);
      run_txn(vecs[v].drv, pkt, vecs[v].fl, pops, pushes, pop_at, push_at, push_cycles, timeout);
      chk($sformatf("v%0d_timeout", v), 512'(timeout), 512'd0);
      chk($sformatf("v%0d_pop", v), 512'(pops), 512'(4'(1) << vecs[v].drv));
      chk($sformatf("v%0d_pop_at", v), 512'(pop_at), 512'd2);
      chk($sformatf("v%0d_push", v), 512'(pushes), 512'(vecs[v].exp_push));
      chk($sformatf("v%0d_push_cycles", v), 512'(push_cycles), (vecs[v].exp_push != 4'b0000) ? 512'd1 : 512'd0);
      if (vecs[v].exp_push != 4'b0000) begin
        chk($sformatf("v%0d_push_at", v), 512'(push_at), 512'd4);
        chk($sformatf("v%0d_dpush", v), d_push, {4{pkt}});
      end
      chk($sformatf("v%0d_drop", v), 512'(drop_cnt), 512'(vecs[v].exp_drop));
      tick();
    end

    // Round robin with all drivers requesting continuously
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) d_pop[i*128 +: 128] = mk_pkt(8'((i + 1) % 4), 8'(i), 16'(16'h100 + i));
    pndng = 4'b1111;
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      tick();
      if (pop != 4'b0000) begin seq[n] = pop; n++; end
    end
    pndng = '0;
    chk("rr_count", 512'(n), 512'd5);
    for (int k = 0; k < n; k++) chk($sformatf("rr_grant%0d", k), 512'(seq[k]), 512'(4'(1) << (k % 4)));
    wait_idle("rr_idle");

    // Destination full for five cycles while the packet waits
    pkt = mk_pkt(8'd3, 8'd2, 16'h55);
    full = 4'b1000;
    d_pop = '0;
    d_pop[2*128 +: 128] = pkt;
    pndng = 4'b0100;
    stall_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (pop != 4'b0000) pndng &= ~pop;
      if (c >= 3 && (push != 4'b0000 || !busy)) stall_ok = 1'b0;
    end
    chk("stall_hold", 512'(stall_ok), 512'd1);
    full = 4'b0000;
    tick();
    chk("stall_push", 512'(push), 512'(4'b1000));
    chk("stall_dpush", d_push, {4{pkt}});
    wait_idle("stall_idle");

    // Reset while waiting; pointer must restart at 0
    pkt = mk_pkt(8'd3, 8'd1, 16'h66);
    full = 4'b1000;
    d_pop = '0;
    d_pop[1*128 +: 128] = pkt;
    pndng = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (pop != 4'b0000) pndng &= ~pop;
    end
    chk("pre_rst_busy", 512'(busy), 512'd1);
    reset = 1'b0;
    #1;
    chk("async_pop", 512'(pop), 512'd0);
    chk("async_push", 512'(push), 512'd0);
    chk("async_busy", 512'(busy), 512'd0);
    chk("async_drop", 512'(drop_cnt), 512'd0);
    chk("async_dpush", d_push, 512'd0);
    full = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) d_pop[i*128 +: 128] = mk_pkt(8'd0, 8'(i), 16'h77);
    pndng = 4'b1110;
    pops = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pop != 4'b0000) begin pops = pop; break; end
    end
    pndng = '0;
    chk("post_rst_grant", 512'(pops), 512'(4'b0010));
    wait_idle("post_rst_idle");

    // Saturating drop counter at width 2
    for (int k = 0; k < 4; k++) begin
      d_pop2 = '0;
      d_pop2[127:0] = mk_pkt(8'd9, 8'd0, 16'(k));
      pndng2 = 4'b0001;
      timeout = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (pop2 != 4'b0000) pndng2 = '0;
        if (!busy2 && c > 1) begin timeout = 1'b0; break; end
      end
      pndng2 = '0;
      chk($sformatf("sat%0d_timeout", k), 512'(timeout), 512'd0);
      chk($sformatf("sat%0d_drop", k), 512'(drop_cnt2), 512'(exp_sat[k]));
      chk($sformatf("sat%0d_push", k), 512'(push2), 512'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
